// File: rtl/reg_file_dumper_pkg.sv
// Shared CPU debug-dump definitions: dumper FSM encoding, word geometry and
// the byte order that the host-side decoder also relies on.
package reg_file_dumper_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_SEND      = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_NEXT      = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_LOAD      = ST_LOAD,
    S_SEND      = ST_SEND,
    S_WAIT_ACK  = ST_WAIT_ACK,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_NEXT      = ST_NEXT,
    S_DONE      = ST_DONE
  } dump_state_e;

  localparam int DEF_DATA_W     = 32;
  localparam int BYTES_PER_WORD = DEF_DATA_W / 8;

  // Words go out most significant byte first; the host decoder assumes this.
  localparam bit DUMP_MSB_FIRST = 1'b1;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/reg_file_dumper_if.sv
// Dumper-facing bundle: dump control, register-file debug read port and the
// UART TX byte handshake. master = dumper, slave = CPU/UART side.
interface reg_file_dumper_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rf_read_addr;
  logic [DATA_W-1:0] rf_read_data;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;

  modport master (
    input  start, rf_read_data, tx_busy,
    output busy, done, rf_read_addr, tx_data, tx_start
  );

  modport slave (
    output start, rf_read_data, tx_busy,
    input  busy, done, rf_read_addr, tx_data, tx_start
  );
endinterface

// File: rtl/reg_file_dumper.sv
// Register-file debug dumper: walks every register through a spare read port
// and streams each word MSB byte first into the UART TX start/busy handshake.
module reg_file_dumper
  import reg_file_dumper_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  reg_file_dumper_if.master  bus
);

  localparam int BPW = bytes_per_word(DATA_W);
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BCW-1:0]    LAST_BYTE = BCW'(BPW - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d, word_shl;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;

  assign word_shl = word_q << 8;

  // tx_start is registered, so it is armed on the transition into SEND
  // whenever the UART is already idle; otherwise SEND arms it itself.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
          idx_d   = '0;
          addr_d  = '0;
        end
      end
      S_LOAD: begin
        word_d     = bus.rf_read_data;
        byte_cnt_d = '0;
        state_d    = S_SEND;
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = bus.rf_read_data[DATA_W-1 -: 8];
        end
      end
      S_SEND: begin
        if (tx_start_q) begin
          state_d = S_WAIT_ACK;
        end else if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = word_q[DATA_W-1 -: 8];
        end
      end
      S_WAIT_ACK: begin
        if (bus.tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = S_NEXT;
          end else begin
            word_d     = word_shl;
            byte_cnt_d = byte_cnt_q + 1'b1;
            tx_start_d = 1'b1;
            tx_data_d  = word_shl[DATA_W-1 -: 8];
            state_d    = S_SEND;
          end
        end
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          addr_d  = idx_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.rf_read_addr = addr_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_start     = tx_start_q;

endmodule
